nibble_packer: RTL and testbench
================================

Name: nibble_packer

Overview:
- Assembles a stream of 4-bit nibbles into bytes and buffers the bytes for a byte-wide consumer.
- Sits directly upstream of the byte/nibble manipulation stage and feeds it packed `databyte`-style values.
- Uses valid/ready handshakes on both sides.
- Internal storage is an unpacked array of bytes used as a circular FIFO.

Parameters:
- DEPTH, 8, number of byte entries in the FIFO; power of 2, minimum 2.
- MSN_FIRST, 1, 1: first nibble of a pair goes to bits [7:4]; 0: first nibble goes to bits [3:0].

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- nib_in  in  4  input nibble.
- nib_valid  in  1  nib_in is valid this cycle.
- nib_ready  out  1  packer accepts nib_in this cycle.
- flush  in  1  request to pad a held half-byte with 4'h0 and push it.
- byte_out  out  8  head-of-FIFO byte.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer takes byte_out this cycle.
- count  out  $clog2(DEPTH)+1  bytes currently in the FIFO.
- half  out  1  one nibble is held awaiting its partner.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - count=0, half=0, byte_valid=0, held nibble=4'h0, read/write pointers=0.
  - FIFO contents are not cleared.
  - Reset mid-stream discards the held nibble and all buffered bytes.
- Accept on the input side: accept = nib_valid && nib_ready.
- Pop on the output side: pop = byte_valid && byte_ready.
- nib_ready = !half || (count < DEPTH). It is combinational from registers only and never depends on byte_ready.
- Accept with half=0: store nib_in in the held register; half becomes 1. No FIFO write.
- Accept with half=1: write the packed byte to the FIFO; half becomes 0.
  - MSN_FIRST=1: byte is {held, nib_in}.
  - MSN_FIRST=0: byte is {nib_in, held}.
- Flush:
  - Honoured when flush && half && !accept && count<DEPTH.
  - Writes {held,4'h0} (MSN_FIRST=1) or {4'h0,held} (MSN_FIRST=0); half becomes 0.
  - flush with half=0 has no effect.
  - flush coinciding with an accept that completes a byte is ignored; the real nibble wins.
  - flush while full is ignored. The requester holds flush until half=0.
- Output: byte_out = fifo[rd_ptr] and byte_valid = (count!=0), both combinational from registers.
  - byte_out and byte_valid are stable until popped.
  - byte_out is don't-care when byte_valid=0.
- Latency: the second nibble accepted at edge N gives byte_valid=1 after edge N, i.e. the byte is visible in the following cycle.
- Simultaneous write and pop: count is unchanged and both pointers advance. This is legal when full, but nib_ready does not exploit it.
- Pointers wrap modulo DEPTH. count never exceeds DEPTH and never underflows.
- A pop when empty is impossible by construction (byte_valid=0).

Optional Feature:
- Macro: NIBBLE_PACKER_STATS_EN.
- Defined:
  - Adds output port `bytes_packed` (16 bits).
  - Increments on every FIFO write, including flush-padded bytes.
  - Saturates at 16'hFFFF; reset to 0 by rst_n.
  - Adds output `pad_count` (8 bits), counting flush-padded bytes; saturates at 8'hFF.
- Undefined: both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Package `nibble_pkg`:
  - typedef `nibble_t` (logic [3:0]) and typedef `byte_t` (logic [7:0]).
  - localparam `PAD_NIBBLE` = 4'h0.
  - function `pack_nibbles(first, second, msn_first)` returning byte_t.
- Sub-module `byte_fifo` (DEPTH parameter):
  - Contains the storage array, the pointers, count, and the write/pop interface.
- nibble_packer owns the held-nibble register, half, flush and ready logic, and the optional counters.

Test Plan:
1. Reset then nibbles 4'hA, 4'hF, MSN_FIRST=1, byte_ready=0 -> byte_out=8'hAF, byte_valid=1 and count=1 in the cycle after the second accept.
2. Same nibbles with MSN_FIRST=0 -> byte_out=8'hFA.
3. Nibble 4'hE, then flush for one cycle -> byte 8'hE0 pushed, half=0. With stats enabled: bytes_packed=1, pad_count=1.
4. byte_ready=0, push 16 nibbles 0..F (DEPTH=8) -> count=8 and half=0. A 17th nibble 4'h1 is accepted (half=1). An 18th is stalled (nib_ready=0) until one pop. Pops then return 8'h01, 8'h23, ..., 8'hEF in order.
5. Continuous nibble stream with byte_ready=1 every cycle -> count stays at or below 1. The pointers wrap past DEPTH with no lost or duplicated bytes (scoreboard compare over 100 bytes).
6. Hold half=1 with count=3, assert rst_n=0 for one edge -> count=0, half=0, byte_valid=0. Next nibbles 4'h1, 4'h2 -> 8'h12.

Source files
------------

// File: rtl/nibble_pkg.sv
// Shared types and the nibble-pair packing helper for the nibble packer.
package nibble_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [7:0] byte_t;

  localparam nibble_t PAD_NIBBLE = 4'h0;

  // msn_first=1 puts the first nibble of the pair in bits [7:4]
  function automatic byte_t pack_nibbles(nibble_t first, nibble_t second, logic msn_first);
    return msn_first ? {first, second} : {second, first};
  endfunction

endpackage

// File: rtl/nibble_packer_byte_fifo.sv
// Circular byte FIFO: storage array, wrapping pointers and occupancy count.
module byte_fifo
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  byte_t          mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Contents survive reset; only the pointers and count are cleared
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (wr && !pop)      count <= count + CW'(1);
      else if (!wr && pop) count <= count - CW'(1);
    end
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/nibble_packer.sv
// Packs a nibble stream into bytes and buffers them in a byte FIFO.
// Optional NIBBLE_PACKER_STATS_EN adds bytes_packed / pad_count counters.
module nibble_packer
  import nibble_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter bit          MSN_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [3:0]             nib_in,
  input  logic                   nib_valid,
  output logic                   nib_ready,
  input  logic                   flush,
  output logic [7:0]             byte_out,
  output logic                   byte_valid,
  input  logic                   byte_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   half
`ifdef NIBBLE_PACKER_STATS_EN
  ,
  output logic [15:0]            bytes_packed,
  output logic [7:0]             pad_count
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  nibble_t held;
  logic    full;
  logic    accept;
  logic    complete;
  logic    flush_go;
  logic    wr;
  byte_t   wr_data;
  logic    pop;

  // Ready ignores byte_ready on purpose: no write-through-pop when full
  assign full      = (count == CW'(DEPTH));
  assign nib_ready = !half || !full;
  assign accept    = nib_valid && nib_ready;
  assign complete  = accept && half;
  assign flush_go  = flush && half && !accept && !full;
  assign wr        = complete || flush_go;
  assign wr_data   = complete ? pack_nibbles(held, nib_in, MSN_FIRST)
                              : pack_nibbles(held, PAD_NIBBLE, MSN_FIRST);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      held <= '0;
      half <= 1'b0;
    end else if (accept) begin
      if (!half) held <= nib_in;
      half <= !half;
    end else if (flush_go) begin
      half <= 1'b0;
    end
  end

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (wr),
    .wr_data (wr_data),
    .pop     (pop),
    .rd_data (byte_out),
    .count   (count)
  );

`ifdef NIBBLE_PACKER_STATS_EN
  // Saturating counters of all written bytes and of padded bytes
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bytes_packed <= '0;
      pad_count    <= '0;
    end else begin
      if (wr && bytes_packed != 16'hFFFF) bytes_packed <= bytes_packed + 16'(1);
      if (flush_go && pad_count != 8'hFF) pad_count <= pad_count + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_packer.sv
// Scoreboard bench for nibble_packer; a second instance covers MSN_FIRST=0.
module tb_nibble_packer;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] nin = 4'h0;
  logic       nv = 1'b0;
  logic       fl = 1'b0;
  logic       br = 1'b0;

  logic       nib_ready, byte_valid, half;
  logic [7:0] byte_out;
  logic [3:0] count;
  logic       nib_ready0, byte_valid0, half0;
  logic [7:0] byte_out0;
  logic [3:0] count0;
`ifdef NIBBLE_PACKER_STATS_EN
  logic [15:0] bytes_packed, bytes_packed0;
  logic [7:0]  pad_count, pad_count0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_popped = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_q0[$];
  logic       m_half = 1'b0;
  logic [3:0] m_held = 4'h0;
  int         m_bytes = 0;
  int         m_pads  = 0;

  always #5 clk = ~clk;

  nibble_packer #(.DEPTH(DEPTH), .MSN_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .nib_in(nin), .nib_valid(nv), .nib_ready(nib_ready),
    .flush(fl), .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(br),
    .count(count), .half(half)
`ifdef NIBBLE_PACKER_STATS_EN
    , .bytes_packed(bytes_packed), .pad_count(pad_count)
`endif
  );

  nibble_packer #(.DEPTH(DEPTH), .MSN_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .nib_in(nin), .nib_valid(nv), .nib_ready(nib_ready0),
    .flush(fl), .byte_out(byte_out0), .byte_valid(byte_valid0), .byte_ready(br),
    .count(count0), .half(half0)
`ifdef NIBBLE_PACKER_STATS_EN
    , .bytes_packed(bytes_packed0), .pad_count(pad_count0)
`endif
  );

  // One clock: settle, update model and scoreboard, then advance to next negedge
  task automatic tick();
    logic full_now, acc;
    logic [7:0] e;
    #1;
    if (!rst_n) begin
      exp_q.delete();
      exp_q0.delete();
      m_half  = 1'b0;
      m_held  = 4'h0;
      m_bytes = 0;
      m_pads  = 0;
    end else begin
      full_now = (exp_q.size() == DEPTH);
      n_checks++;
      if (nib_ready !== (!m_half || !full_now)) begin
        n_fail++;
        $display("FAIL nib_ready: got %b expected %b", nib_ready, (!m_half || !full_now));
      end
      n_checks++;
      if (byte_valid !== (exp_q.size() != 0)) begin
        n_fail++;
        $display("FAIL byte_valid: got %b expected %b", byte_valid, (exp_q.size() != 0));
      end
      acc = nv && (!m_half || !full_now);
      if (br && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (byte_out !== e) begin
          n_fail++;
          $display("FAIL byte_out: got %h expected %h", byte_out, e);
        end
        e = exp_q0.pop_front();
        n_checks++;
        if (byte_out0 !== e) begin
          n_fail++;
          $display("FAIL byte_out_lsn: got %h expected %h", byte_out0, e);
        end
        n_popped++;
      end
      if (acc && m_half) begin
        exp_q.push_back({m_held, nin});
        exp_q0.push_back({nin, m_held});
        m_half = 1'b0;
        m_bytes++;
      end else if (acc) begin
        m_held = nin;
        m_half = 1'b1;
      end else if (fl && m_half && !full_now) begin
        exp_q.push_back({m_held, 4'h0});
        exp_q0.push_back({4'h0, m_held});
        m_half = 1'b0;
        m_bytes++;
        m_pads++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nv = 1'b0; fl = 1'b0; br = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    nv = 1'b0; fl = 1'b0; br = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    br = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (count !== 4'd0 || half !== 1'b0 || byte_valid !== 1'b0 || nib_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: count=%0d half=%b valid=%b ready=%b expected 0 0 0 1",
               count, half, byte_valid, nib_ready);
    end
  endtask

  task automatic test_pack();
    br = 1'b0;
    nv = 1'b1; nin = 4'hA; tick();
    nin = 4'hF; tick();
    nv = 1'b0;
    n_checks++;
    if (byte_out !== 8'hAF || byte_valid !== 1'b1 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL pack_msn: byte=%h valid=%b count=%0d expected af 1 1", byte_out, byte_valid, count);
    end
    n_checks++;
    if (byte_out0 !== 8'hFA || count0 !== 4'd1) begin
      n_fail++;
      $display("FAIL pack_lsn: byte=%h count=%0d expected fa 1", byte_out0, count0);
    end
    drain();
  endtask

  task automatic test_flush();
    do_reset();
    nv = 1'b1; nin = 4'hE; tick();
    nv = 1'b0; fl = 1'b1; tick();
    fl = 1'b0;
    n_checks++;
    if (half !== 1'b0 || count !== 4'd1 || byte_out !== 8'hE0 || byte_out0 !== 8'h0E) begin
      n_fail++;
      $display("FAIL flush_pad: half=%b count=%0d byte=%h lsn=%h expected 0 1 e0 0e",
               half, count, byte_out, byte_out0);
    end
    fl = 1'b1; tick();
    fl = 1'b0;
    n_checks++;
    if (count !== 4'd1) begin
      n_fail++;
      $display("FAIL flush_idle: count=%0d expected 1", count);
    end
`ifdef NIBBLE_PACKER_STATS_EN
    n_checks++;
    if (bytes_packed !== 16'd1 || pad_count !== 8'd1) begin
      n_fail++;
      $display("FAIL stats_flush: bytes_packed=%0d pad_count=%0d expected 1 1", bytes_packed, pad_count);
    end
`endif
    drain();
  endtask

  task automatic test_full();
    do_reset();
    nv = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nin = 4'(i);
      tick();
    end
    n_checks++;
    if (count !== 4'd8 || half !== 1'b0) begin
      n_fail++;
      $display("FAIL full_fill: count=%0d half=%b expected 8 0", count, half);
    end
    nin = 4'h1; tick();
    n_checks++;
    if (half !== 1'b1 || count !== 4'd8) begin
      n_fail++;
      $display("FAIL full_17th: half=%b count=%0d expected 1 8", half, count);
    end
    nin = 4'h2; fl = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (nib_ready !== 1'b0 || count !== 4'd8 || half !== 1'b1) begin
        n_fail++;
        $display("FAIL full_stall: ready=%b count=%0d half=%b expected 0 8 1", nib_ready, count, half);
      end
    end
    fl = 1'b0; br = 1'b1; tick();
    br = 1'b0; tick();
    nv = 1'b0;
    n_checks++;
    if (count !== 4'd8 || half !== 1'b0) begin
      n_fail++;
      $display("FAIL full_resume: count=%0d half=%b expected 8 0", count, half);
    end
`ifdef NIBBLE_PACKER_STATS_EN
    n_checks++;
    if (bytes_packed !== 16'(m_bytes) || pad_count !== 8'd0) begin
      n_fail++;
      $display("FAIL stats_full: bytes_packed=%0d pad_count=%0d expected %0d 0", bytes_packed, pad_count, m_bytes);
    end
`endif
    drain();
    n_checks++;
    if (byte_valid !== 1'b0 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL full_drain: valid=%b left=%0d expected 0 0", byte_valid, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int start;
    do_reset();
    start = n_popped;
    br = 1'b1; nv = 1'b1;
    for (int i = 0; i < 200; i++) begin
      nin = 4'($urandom_range(0, 15));
      tick();
      n_checks++;
      if (count > 4'd1) begin
        n_fail++;
        $display("FAIL stream_count: count=%0d expected <=1", count);
      end
    end
    nv = 1'b0;
    tick();
    n_checks++;
    if (n_popped - start != 100 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_total: popped=%0d left=%0d expected 100 0", n_popped - start, exp_q.size());
    end
    br = 1'b0;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    nv = 1'b1;
    for (int i = 0; i < 7; i++) begin
      nin = 4'(i + 3);
      tick();
    end
    nv = 1'b0;
    n_checks++;
    if (count !== 4'd3 || half !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_setup: count=%0d half=%b expected 3 1", count, half);
    end
    do_reset();
    n_checks++;
    if (count !== 4'd0 || half !== 1'b0 || byte_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d half=%b valid=%b expected 0 0 0", count, half, byte_valid);
    end
    nv = 1'b1; nin = 4'h1; tick();
    nin = 4'h2; tick();
    nv = 1'b0;
    n_checks++;
    if (byte_out !== 8'h12 || count !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_after: byte=%h count=%0d expected 12 1", byte_out, count);
    end
    drain();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_pack();
    test_flush();
    test_full();
    test_back_to_back();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
